// File: rtl/priority_pkg.sv
// Shared types and constants for the priority arbiter: FSM state encoding
// and the per-requester age counter width with its saturating increment.
package priority_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int AGE_W = 8;

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age);
    return (age == '1) ? age : age + 1'b1;
  endfunction

endpackage

// File: rtl/priority_pick.sv
// Combinational winner selection: highest key among active requesters, ties
// resolved round-robin starting just after the previous grant.
module priority_pick #(
  parameter int N  = 4,
  parameter int KW = 3,
  parameter int SW = 2
) (
  input  logic [N*KW-1:0] keys_i,
  input  logic [N-1:0]    req_i,
  input  logic [SW-1:0]   last_grant_i,
  output logic [N-1:0]    win_onehot_o,
  output logic [SW-1:0]   win_idx_o,
  output logic            win_valid_o
);

  logic          found;
  logic [KW-1:0] best_key;
  int            best_idx;
  int            idx;

  // Scanning in round-robin order with a strict '>' keeps the first of equal keys.
  always_comb begin
    found    = 1'b0;
    best_key = '0;
    best_idx = 0;
    idx      = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last_grant_i) + k;
      if (idx >= N) idx = idx - N;
      if (req_i[idx] && (!found || keys_i[idx*KW +: KW] > best_key)) begin
        found    = 1'b1;
        best_key = keys_i[idx*KW +: KW];
        best_idx = idx;
      end
    end
    win_valid_o  = found;
    win_onehot_o = '0;
    if (found) win_onehot_o[best_idx] = 1'b1;
    win_idx_o = SW'(best_idx);
  end

endmodule

// File: rtl/priority_arbiter.sv
// Priority arbiter with round-robin tie-break and age-based starvation boost,
// feeding a single registered valid/ready output stage.
module priority_arbiter
  import priority_pkg::*;
#(
  parameter int N_SIGNALS        = 4,
  parameter int N_SIGNAL_WIDTH   = 8,
  parameter int N_PRIORITY_WIDTH = 2,
  parameter int AGE_LIMIT        = 8,
  localparam int SEL_W = (N_SIGNALS > 1) ? $clog2(N_SIGNALS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_SIGNALS-1:0]                 req,
  input  logic [N_SIGNALS*N_PRIORITY_WIDTH-1:0] req_prio,
  input  logic [N_SIGNALS*N_SIGNAL_WIDTH-1:0]  req_data,
  output logic [N_SIGNALS-1:0]                 gnt,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [N_SIGNAL_WIDTH-1:0]            out_data,
  output logic [SEL_W-1:0]                     out_sel,
  output logic [N_PRIORITY_WIDTH-1:0]          out_prio
);

  localparam int KEY_W = N_PRIORITY_WIDTH + 1;

  state_t                        state_q, state_d;
  logic [N_SIGNAL_WIDTH-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0]              out_sel_q, out_sel_d;
  logic [N_PRIORITY_WIDTH-1:0]   out_prio_q, out_prio_d;
  logic [SEL_W-1:0]              last_grant_q, last_grant_d;
  logic [AGE_W-1:0]              age_q [N_SIGNALS];
  logic [AGE_W-1:0]              age_d [N_SIGNALS];

  logic [N_SIGNALS*KEY_W-1:0]    keys;
  logic [N_SIGNALS-1:0]          win_onehot;
  logic [SEL_W-1:0]              win_idx;
  logic                          win_valid;
  logic                          stall;
  logic                          arb_event;

  // Starved requesters get an extra MSB so they outrank any plain priority.
  always_comb begin
    keys = '0;
    for (int i = 0; i < N_SIGNALS; i++) begin
      keys[i*KEY_W +: KEY_W] = {(age_q[i] >= AGE_W'(AGE_LIMIT)),
                                req_prio[i*N_PRIORITY_WIDTH +: N_PRIORITY_WIDTH]};
    end
  end

  priority_pick #(
    .N  (N_SIGNALS),
    .KW (KEY_W),
    .SW (SEL_W)
  ) u_pick (
    .keys_i       (keys),
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .win_onehot_o (win_onehot),
    .win_idx_o    (win_idx),
    .win_valid_o  (win_valid)
  );

  assign stall     = (state_q == BUSY) && !out_ready;
  assign arb_event = win_valid && !stall;
  assign gnt       = (arb_event && rst) ? win_onehot : '0;

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    out_prio_d   = out_prio_q;
    last_grant_d = last_grant_q;
    if (arb_event) begin
      state_d      = BUSY;
      out_data_d   = req_data[int'(win_idx)*N_SIGNAL_WIDTH +: N_SIGNAL_WIDTH];
      out_sel_d    = win_idx;
      out_prio_d   = req_prio[int'(win_idx)*N_PRIORITY_WIDTH +: N_PRIORITY_WIDTH];
      last_grant_d = win_idx;
    end else if (!stall) begin
      state_d = IDLE;
    end
  end

  // Ages freeze while the output is stalled; a dropped request always clears.
  always_comb begin
    for (int i = 0; i < N_SIGNALS; i++) begin
      age_d[i] = age_q[i];
      if (!req[i]) begin
        age_d[i] = '0;
      end else if (arb_event) begin
        age_d[i] = win_onehot[i] ? '0 : age_inc(age_q[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      out_prio_q   <= '0;
      last_grant_q <= SEL_W'(N_SIGNALS - 1);
      for (int i = 0; i < N_SIGNALS; i++) age_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      out_prio_q   <= out_prio_d;
      last_grant_q <= last_grant_d;
      for (int i = 0; i < N_SIGNALS; i++) age_q[i] <= age_d[i];
    end
  end

  assign out_valid = (state_q == BUSY);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_prio  = out_prio_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed bench for priority_arbiter: reset winner, priority order,
// round-robin, starvation aging, backpressure and asynchronous mid-reset.
module tb_priority_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  reqPrio;
  logic [31:0] reqData;
  logic [3:0]  gnt;
  logic        outValid;
  logic        outReady;
  logic [7:0]  outData;
  logic [1:0]  outSel;
  logic [1:0]  outPrio;

  int checks = 0;
  int errors = 0;

  priority_arbiter #(
    .N_SIGNALS        (4),
    .N_SIGNAL_WIDTH   (8),
    .N_PRIORITY_WIDTH (2),
    .AGE_LIMIT        (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_prio  (reqPrio),
    .req_data  (reqData),
    .gnt       (gnt),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .out_sel   (outSel),
    .out_prio  (outPrio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [7:0] p, input logic rdy);
    req      = r;
    reqPrio  = p;
    outReady = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dataOf(input int idx);
    return 8'hA0 + 8'(idx * 17);
  endfunction

  initial begin
    int expSeq [5];
    rst      = 1'b0;
    req      = '0;
    reqPrio  = '0;
    reqData  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    outReady = 1'b1;

    // Reset values, then index 0 captured on the first edge after release
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_valid", outValid, 0);
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_data", outData, 0);
    checkOutput("rst_sel", outSel, 0);
    #2;
    rst = 1'b1;
    applyStimulus(4'b0001, 8'b0000_0001, 1'b1);
    checkOutput("first_gnt", gnt, 4'b0001);
    tick();
    checkOutput("first_valid", outValid, 1);
    checkOutput("first_sel", outSel, 0);
    checkOutput("first_data", outData, 8'hA0);
    checkOutput("first_prio", outPrio, 1);
    applyStimulus(4'b0000, 8'b0000_0001, 1'b1);
    checkOutput("drain_gnt", gnt, 0);
    tick();
    checkOutput("drain_idle", outValid, 0);

    // Priority order 2,3,1,0 with prios 0,1,3,2; winners drop their request
    expSeq = '{2, 3, 1, 0, 0};
    applyStimulus(4'b1111, 8'b10_11_01_00, 1'b1);
    for (int s = 0; s < 4; s++) begin
      checkOutput($sformatf("prio_gnt%0d", s), gnt, 32'(4'b0001 << expSeq[s]));
      tick();
      checkOutput($sformatf("prio_sel%0d", s), outSel, expSeq[s]);
      checkOutput($sformatf("prio_data%0d", s), outData, dataOf(expSeq[s]));
      req[expSeq[s]] = 1'b0;
      #1;
    end
    tick();
    checkOutput("prio_idle", outValid, 0);

    // Fresh reset so the round-robin pointer starts at index 0
    rst = 1'b0;
    #2;
    rst = 1'b1;
    expSeq = '{0, 1, 2, 3, 0};
    applyStimulus(4'b1111, 8'b10_10_10_10, 1'b1);
    for (int s = 0; s < 5; s++) begin
      checkOutput($sformatf("rr_gnt%0d", s), gnt, 32'(4'b0001 << expSeq[s]));
      tick();
      checkOutput($sformatf("rr_sel%0d", s), outSel, expSeq[s]);
    end
    applyStimulus(4'b0000, 8'b10_10_10_10, 1'b1);
    tick();
    checkOutput("rr_idle", outValid, 0);

    // Aging: req0 prio 0 loses three times, then wins when starved
    expSeq = '{1, 1, 1, 0, 0};
    applyStimulus(4'b0011, 8'b00_00_11_00, 1'b1);
    for (int s = 0; s < 4; s++) begin
      checkOutput($sformatf("age_gnt%0d", s), gnt, 32'(4'b0001 << expSeq[s]));
      tick();
      checkOutput($sformatf("age_sel%0d", s), outSel, expSeq[s]);
    end
    checkOutput("age_prio", outPrio, 0);
    applyStimulus(4'b0000, 8'b00_00_11_00, 1'b1);
    tick();
    checkOutput("age_idle", outValid, 0);

    // Backpressure: capture index 1, stall 5 cycles, then index 2 wins at once
    applyStimulus(4'b0110, 8'b10_10_10_10, 1'b0);
    checkOutput("bp_first_gnt", gnt, 4'b0010);
    tick();
    checkOutput("bp_first_sel", outSel, 1);
    for (int s = 0; s < 5; s++) begin
      checkOutput($sformatf("bp_gnt%0d", s), gnt, 0);
      checkOutput($sformatf("bp_data%0d", s), outData, 8'hB1);
      checkOutput($sformatf("bp_valid%0d", s), outValid, 1);
      checkOutput($sformatf("bp_age1_%0d", s), dut.age_q[1], 0);
      checkOutput($sformatf("bp_age2_%0d", s), dut.age_q[2], 1);
      tick();
    end
    applyStimulus(4'b0110, 8'b10_10_10_10, 1'b1);
    checkOutput("bp_release_gnt", gnt, 4'b0100);
    tick();
    checkOutput("bp_release_sel", outSel, 2);
    checkOutput("bp_release_data", outData, 8'hC2);

    // Mid-reset while BUSY with a grant pending
    applyStimulus(4'b1111, 8'b10_10_10_10, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mr_valid", outValid, 0);
    checkOutput("mr_gnt", gnt, 0);
    checkOutput("mr_data", outData, 0);
    tick();
    checkOutput("mr_hold_valid", outValid, 0);
    checkOutput("mr_hold_gnt", gnt, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mr_after_gnt", gnt, 4'b0001);
    tick();
    checkOutput("mr_after_sel", outSel, 0);
    checkOutput("mr_after_data", outData, 8'hA0);
    applyStimulus(4'b0000, 8'b10_10_10_10, 1'b1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 The block SHALL have parameter N_SIGNALS, default 4, meaning the number of requesters.
REQ-002 The block SHALL have parameter N_SIGNAL_WIDTH, default 8, meaning the data width per requester.
REQ-003 The block SHALL have parameter N_PRIORITY_WIDTH, default 2, meaning the priority field width; a larger value wins.
REQ-004 The block SHALL have parameter AGE_LIMIT, default 8, meaning the number of consecutive lost arbitrations before a requester is starved; legal range 1..255.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 The block SHALL have port req, input, N_SIGNALS bits: per-requester request, held until granted.
REQ-008 The block SHALL have port req_prio, input, N_SIGNALS x N_PRIORITY_WIDTH bits: per-requester priority.
REQ-009 The block SHALL have port req_data, input, N_SIGNALS x N_SIGNAL_WIDTH bits: per-requester payload.
REQ-010 The block SHALL have port gnt, output, N_SIGNALS bits: one-hot, single-cycle pulse marking the requester captured this cycle.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the output holds a transfer.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream accepts the transfer.
REQ-013 The block SHALL have port out_data, output, N_SIGNAL_WIDTH bits: the captured payload.
REQ-014 The block SHALL have port out_sel, output, clog2(N_SIGNALS) bits: the index of the captured requester.
REQ-015 The block SHALL have port out_prio, output, N_PRIORITY_WIDTH bits: the captured requester's priority.

Function
REQ-016 The FSM SHALL have two states, IDLE (out_valid=0) and BUSY (out_valid=1).
REQ-017 The block SHALL define an arbitration event as any req bit high while in IDLE, or while in BUSY with out_ready=1.
REQ-018 On an arbitration event the block SHALL select the winner, pulse gnt for the winner in that same cycle, register req_data, index and prio on the next edge, and enter or remain in BUSY.
REQ-019 Latency SHALL be 1 cycle from req in IDLE to out_valid; back-to-back transfers at 1 per cycle SHALL be sustained.
REQ-020 Winner key SHALL be the concatenation of the starved bit and req_prio; the highest key wins.
REQ-021 Key ties SHALL be broken round-robin, searching from index last_grant+1 with wrap to 0; last_grant resets to N_SIGNALS-1, so index 0 wins first.
REQ-022 Each requester SHALL have a saturating age counter that increments on every arbitration event where its req is high and it loses.
REQ-023 Each age counter SHALL clear when its requester is granted or when its req is low.
REQ-024 A requester SHALL be starved when its age is at least AGE_LIMIT.
REQ-025 In BUSY with out_ready=0, out_data, out_sel and out_prio SHALL be stable, gnt SHALL be 0, and ages SHALL not change.
REQ-026 In BUSY with out_ready=1 and no req, the block SHALL return to IDLE.
REQ-027 A req bit that drops before its grant SHALL be ignored, with no gnt and its age cleared.
REQ-028 The granted requester's req bit SHALL be ignored during the grant cycle; a req still high in the following cycle SHALL count as a new request.

Reset
REQ-029 While rst=0 the block SHALL force state to IDLE, out_valid, gnt, out_data, out_sel and out_prio to 0, all ages to 0, and last_grant to N_SIGNALS-1, regardless of clk.
REQ-030 An in-flight transfer SHALL be dropped on reset, with no gnt pulse.
REQ-031 The first arbitration SHALL occur on the first rising edge after rst rises.

Structure
REQ-032 Package priority_pkg SHALL hold the state enum (IDLE, BUSY) and the age counter width constant (8 bits).
REQ-033 Sub-module priority_pick SHALL be purely combinational, taking keys, req and last_grant and producing a one-hot winner plus index; it SHALL be instanced once.
REQ-034 All registers SHALL reside in priority_arbiter.

Verification
REQ-035 The bench SHALL check reset winner: req=0001, prio0=1 -> gnt=0001 at cycle 0, out_valid=1, out_sel=0 and out_data=req_data[0] at cycle 1.
REQ-036 The bench SHALL check priority: req=1111, prios 0,1,3,2 with out_ready=1 -> grant order 2,3,1,0, one per cycle.
REQ-037 The bench SHALL check round-robin: all prios=2, req=1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0.
REQ-038 The bench SHALL check aging: req0 prio=0 continuous, req1 prio=3 continuous, AGE_LIMIT=3, out_ready=1 -> req0 granted on the 4th arbitration.
REQ-039 The bench SHALL check backpressure: out_ready=0 for 5 cycles with req=0110 -> out_data stable, gnt=0, ages unchanged; then out_ready=1 -> the next grant issues that cycle.
REQ-040 The bench SHALL check mid-reset: rst=0 while BUSY -> out_valid=0 and gnt=0 immediately, without waiting for clk; after release the first winner is index 0 on a prio tie.
